cpuc_mux_arb: RTL

CPUC_MUX_ARB -- requirements
Module: cpuc_mux_arb

---
 rtl/cpuc_package.sv | 4 +
 rtl/cpuc_mux_arb_if.sv | 26 ++
 rtl/cpuc_mux_arb.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpuc_package.sv
// Shared constants for the cpuc datapath blocks.
package cpuc_package;
    parameter int DATA_WIDTH = 8;
endpackage

// File: rtl/cpuc_mux_arb_if.sv
// Bundles both requester handshakes and the output handshake of cpuc_mux_arb.
// slave is the arbiter's view; master is the view of whoever drives it.
interface cpuc_mux_arb_if #(
    parameter int DATA_WIDTH = cpuc_package::DATA_WIDTH
);
    logic                  in0_valid;
    logic [DATA_WIDTH-1:0] in0_data;
    logic                  in0_ready;
    logic                  in1_valid;
    logic [DATA_WIDTH-1:0] in1_data;
    logic                  in1_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sel;
    logic                  out_ready;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/cpuc_mux_arb.sv
// Two-requester arbiter feeding a single registered output slot through cpuc_mux.
// Define CPUC_MUX_ARB_RR_EN for round-robin tie breaking; default is fixed priority to requester 0.
module cpuc_mux #(
    parameter int DATA_WIDTH = cpuc_package::DATA_WIDTH
) (
    input  logic                  ctrl_i,
    input  logic [DATA_WIDTH-1:0] in0_i,
    input  logic [DATA_WIDTH-1:0] in1_i,
    output logic [DATA_WIDTH-1:0] out_o
);
    assign out_o = ctrl_i ? in1_i : in0_i;
endmodule

module cpuc_mux_arb #(
    parameter int DATA_WIDTH = cpuc_package::DATA_WIDTH
) (
    input logic           Clk,
    input logic           Rst_N,
    cpuc_mux_arb_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] muxData;
    logic                  loadEn;
    logic                  anyValid;
    logic                  grant;
    logic                  accept;
`ifdef CPUC_MUX_ARB_RR_EN
    logic                  lastGrant_q, lastGrant_d;
`endif

    // Readys are gated by Rst_N so nothing is handshaken while reset is held.
    always_comb begin
        loadEn   = (state_q == EMPTY) || bus.out_ready;
        anyValid = bus.in0_valid || bus.in1_valid;
        if (bus.in0_valid && bus.in1_valid) begin
`ifdef CPUC_MUX_ARB_RR_EN
            grant = ~lastGrant_q;
`else
            grant = 1'b0;
`endif
        end else begin
            grant = bus.in1_valid;
        end
        accept = loadEn && anyValid && Rst_N;
    end

    assign bus.in0_ready = accept && !grant;
    assign bus.in1_ready = accept && grant;

    cpuc_mux #(.DATA_WIDTH(DATA_WIDTH)) uMux (
        .ctrl_i (grant),
        .in0_i  (bus.in0_data),
        .in1_i  (bus.in1_data),
        .out_o  (muxData)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
`ifdef CPUC_MUX_ARB_RR_EN
        lastGrant_d = lastGrant_q;
`endif
        if (accept) begin
            state_d = FULL;
            data_d  = muxData;
            sel_d   = grant;
`ifdef CPUC_MUX_ARB_RR_EN
            lastGrant_d = grant;
`endif
        end else if (bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 1'b0;
`ifdef CPUC_MUX_ARB_RR_EN
            lastGrant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
`ifdef CPUC_MUX_ARB_RR_EN
            lastGrant_q <= lastGrant_d;
`endif
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
endmodule
